// File: rtl/fifo_read_sequencer.sv
// fifo_read_sequencer
//   Drains a non-showahead scfifo into a valid/ready stream. The FIFO's read
//   data appears one cycle after rdreq. A 2-entry buffer hides that latency,
//   so the stream runs at 1 word/cycle while the consumer is ready.
//   The block also sequences a flush: it stops reads, drops everything it
//   holds, pulses the FIFO's sclr for one cycle, then pulses flush_done.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   fifo_empty, fifo_q  scfifo status / read data (valid the cycle after rdreq)
//   fifo_rdreq          scfifo read request (combinational)
//   fifo_sclr           scfifo synchronous clear (registered)
//   out_valid/out_data  head of the output buffer
//   out_ready           consumer accept; handshake = out_valid & out_ready
//   flush               flush request, honoured only in RUN
//   busy, flush_done    flush in progress / one-cycle completion pulse
//   word_count          handshakes since reset (wraps)
module fifo_read_sequencer #(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_q,
  output logic                   fifo_rdreq,
  output logic                   fifo_sclr,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic                   busy,
  output logic                   flush_done,
  output logic [COUNT_WIDTH-1:0] word_count
);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR, DONE} state_t;

  state_t                          state;
  logic [1:0][DATA_WIDTH-1:0]      buf_q;     // [0] is the head
  logic [1:0]                      count;     // buffered words, 0..2
  logic                            inflight;  // a read issued last cycle lands this edge
  logic                            hs;
  logic [2:0]                      occ;       // occupancy after this cycle's pop

  assign hs        = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = buf_q[0];

  // Reserve a slot for every word that will land, so the buffer never overflows.
  assign occ        = 3'(count) + 3'(inflight) - 3'(hs);
  assign fifo_rdreq = (state == RUN) && !reset && !fifo_empty && (occ < 3'd2);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      buf_q      <= '0;
      count      <= 2'd0;
      inflight   <= 1'b0;
      fifo_sclr  <= 1'b0;
      busy       <= 1'b0;
      flush_done <= 1'b0;
      word_count <= '0;
    end else begin
      inflight   <= fifo_rdreq;
      fifo_sclr  <= 1'b0;
      flush_done <= 1'b0;
      if (hs) word_count <= word_count + 1'b1;

      case (state)
        RUN: begin
          if (flush) begin
            // A handshake this cycle is already counted; the rest is dropped,
            // including any word still in flight.
            state <= DRAIN;
            busy  <= 1'b1;
            count <= 2'd0;
          end else begin
            case ({inflight, hs})
              2'b10: begin
                if (count == 2'd0) buf_q[0] <= fifo_q;
                else               buf_q[1] <= fifo_q;
                count <= count + 2'd1;
              end
              2'b01: begin
                buf_q[0] <= buf_q[1];
                count    <= count - 2'd1;
              end
              2'b11: begin
                if (count == 2'd1) begin
                  buf_q[0] <= fifo_q;
                end else begin
                  buf_q[0] <= buf_q[1];
                  buf_q[1] <= fifo_q;
                end
              end
              default: ;
            endcase
          end
        end
        DRAIN: begin
          // The in-flight word (if any) lands now and is ignored.
          state     <= CLEAR;
          fifo_sclr <= 1'b1;
        end
        CLEAR: begin
          state      <= DONE;
          flush_done <= 1'b1;
        end
        DONE: begin
          state <= RUN;
          busy  <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_sequencer.sv
// Bench for fifo_read_sequencer. A behavioural scfifo (queue) feeds the DUT.
// Every accepted write is pushed onto an expected-word queue; a negedge
// monitor pops it on each handshake. Words that leave the FIFO but are not
// delivered are dropped from the expectation when a flush or reset discards them.
module tb_fifo_read_sequencer;
  localparam int DW = 64, CW = 32, DEPTH = 256;

  logic          clock = 1'b0;
  logic          reset, fifo_empty = 1'b1, fifo_rdreq, fifo_sclr;
  logic [DW-1:0] fifo_q = '0, out_data;
  logic          out_valid, out_ready, flush, busy, flush_done;
  logic [CW-1:0] word_count;

  logic          wr_en;
  logic [DW-1:0] wr_data;

  always #5 clock = ~clock;

  fifo_read_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rdreq(fifo_rdreq), .fifo_sclr(fifo_sclr), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .flush(flush), .busy(busy),
    .flush_done(flush_done), .word_count(word_count)
  );

  int checks = 0, errors = 0;
  logic [DW-1:0] mq[$];     // FIFO contents
  logic [DW-1:0] exp_q[$];  // words still owed to the consumer, in order
  logic s_rd = 1'b0, s_sclr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic void drop(int n);
    for (int i = 0; i < n && exp_q.size() > 0; i++) void'(exp_q.pop_front());
  endfunction

  // scfifo model: non-showahead, q registered on rdreq, 256 deep, writes to full dropped
  always @(posedge clock) begin
    if (s_sclr) begin
      mq.delete();
      exp_q.delete();
    end else begin
      if (s_rd && mq.size() > 0) fifo_q <= mq.pop_front();
      if (wr_en && mq.size() < DEPTH) begin
        mq.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
    end
    fifo_empty <= (mq.size() == 0);
  end

  // Monitor
  int cyc = 0, phase = 0, hs_model = 0, lat_t = -1, lat1 = -1, rd_pulses = 0;
  bit rst_chk = 0, st_arm = 0, prev_rd = 0, facc;
  logic [DW-1:0] st_data;

  always @(negedge clock) begin
    int pend;
    cyc++;
    s_rd   = fifo_rdreq;
    s_sclr = fifo_sclr;
    pend   = exp_q.size() - mq.size();
    if (reset) begin
      chk("rdreq_in_reset", fifo_rdreq, 0);
      drop(pend);
      phase = 0; rst_chk = 1; lat_t = -1; lat1 = -1; st_arm = 0; hs_model = 0; prev_rd = 0;
    end else begin
      if (fifo_rdreq) rd_pulses++;
      if (rst_chk) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_sclr", fifo_sclr, 0);
        chk("rst_word_count", word_count, 0);
        rst_chk = 0;
      end
      if (fifo_empty) chk("rdreq_when_empty", fifo_rdreq, 0);
      if (phase != 0) begin
        chk("rdreq_outside_run", fifo_rdreq, 0);
        chk("valid_in_flush", out_valid, 0);
        chk("busy_in_flush", busy, 1);
        chk("sclr_phase", fifo_sclr, phase == 2);
        chk("done_phase", flush_done, phase == 3);
      end else begin
        chk("busy_idle", busy, 0);
        chk("sclr_idle", fifo_sclr, 0);
        chk("done_idle", flush_done, 0);
        chk("buf_count_le2", (pend - int'(prev_rd)) <= 2, 1);
      end
      if (st_arm) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, st_data);
      end
      if (cyc == lat1)  chk("latency_early", out_valid, 0);
      if (cyc == lat_t) chk("latency_valid", out_valid, 1);
      chk("word_count", word_count, hs_model);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", out_data, 'x);
        else chk("data", out_data, exp_q.pop_front());
        hs_model++;
      end
      facc = flush && (phase == 0);
      if (!facc && phase == 0 && fifo_rdreq && pend == 0) begin
        lat1 = cyc + 1; lat_t = cyc + 2;
      end
      st_arm  = out_valid && !out_ready && !facc;
      st_data = out_data;
      if (facc) begin
        drop(exp_q.size() - mq.size() + int'(fifo_rdreq));
        phase = 1; lat_t = -1; lat1 = -1;
      end else if (phase != 0) begin
        phase = (phase == 3) ? 0 : phase + 1;
      end
      prev_rd = fifo_rdreq;
    end
  end

  // Stimulus
  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d; step(); wr_en = 1'b0;
  endtask

  task automatic rst_pulse();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic wr3();
    wr(64'hDEA1_0000_BEE2_0000 | 64'h0000_DEA1_0000_BEE2 & 64'h0);
  endtask

  localparam logic [DW-1:0] W1 = 64'h0000_0000_DEA1_BEE2;
  localparam logic [DW-1:0] W2 = 64'h0000_0000_DEA3_BEE4;
  localparam logic [DW-1:0] W3 = 64'h0000_0000_DEA5_BEE6;

  int bubbles, budget, nowr;

  initial begin
    reset = 1'b1; out_ready = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (3) step();
    reset = 1'b0; step();

    // 1: three words streamed with the consumer ready
    rst_pulse(); out_ready = 1'b1;
    wr(W1); wr(W2); wr(W3);
    repeat (10) step();
    chk("t1_word_count", word_count, 3);
    chk("t1_fifo_empty", fifo_empty, 1);
    chk("t1_all_delivered", exp_q.size(), 0);

    // 2: backpressure: only two reads, head holds
    rst_pulse(); out_ready = 1'b0; rd_pulses = 0;
    wr(W1); wr(W2); wr(W3);
    repeat (8) step();
    chk("t2_rdreq_pulses", rd_pulses, 2);
    chk("t2_usedw", mq.size(), 1);
    chk("t2_head", out_data, W1);
    out_ready = 1'b1;
    repeat (8) step();
    chk("t2_word_count", word_count, 3);
    chk("t2_all_delivered", exp_q.size(), 0);

    // 3: full FIFO drained without bubbles
    reset = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) wr({32'hC0DE_0000, 32'(i)});
    chk("t3_full", mq.size(), DEPTH);
    reset = 1'b0; out_ready = 1'b1;
    budget = 20;
    while (!out_valid && budget > 0) begin step(); budget--; end
    chk("t3_first_valid", out_valid, 1);
    bubbles = 0; budget = 400;
    while (word_count < 256 && budget > 0) begin
      if (!out_valid) bubbles++;
      step(); budget--;
    end
    chk("t3_bubbles", bubbles, 0);
    chk("t3_word_count", word_count, 256);

    // 4: flush after two handshakes
    rst_pulse(); out_ready = 1'b0;
    for (int i = 0; i < 10; i++) wr({32'hF1F1_0000, 32'(i)});
    out_ready = 1'b1; budget = 30;
    while (word_count < 2 && budget > 0) begin step(); budget--; end
    flush = 1'b1; out_ready = 1'b0; step(); flush = 1'b0;
    repeat (4) step();
    chk("t4_usedw", mq.size(), 0);
    chk("t4_no_valid", out_valid, 0);
    chk("t4_word_count", word_count, 2);
    out_ready = 1'b1;
    wr(64'h1234);
    repeat (6) step();
    chk("t4_after_word_count", word_count, 3);
    chk("t4_all_delivered", exp_q.size(), 0);

    // 5: reset the cycle after an rdreq
    reset = 1'b1; out_ready = 1'b0;
    wr(W1); wr(W2); wr(W3);
    reset = 1'b0; #1;
    chk("t5_rdreq", fifo_rdreq, 1);
    step(); reset = 1'b1;
    step(); reset = 1'b0; #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_count", word_count, 0);
    chk("t5_rst_sclr", fifo_sclr, 0);
    out_ready = 1'b1;
    repeat (10) step();
    chk("t5_word_count", word_count, 2);
    chk("t5_all_delivered", exp_q.size(), 0);

    // 6: random traffic with flushes, resets, full FIFO and stalls
    nowr = 0;
    for (int i = 0; i < 3000; i++) begin
      out_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 39) == 0);
      if (flush) nowr = 4;
      wr_en = (nowr == 0) && ($urandom_range(0, 2) != 0);
      wr_data = {$urandom, $urandom};
      if (nowr > 0) nowr--;
      step();
    end
    wr_en = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    repeat (400) step();
    chk("t6_all_delivered", exp_q.size(), 0);
    chk("t6_fifo_empty", fifo_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
